instr_fetch_mem: RTL and testbench

Parametrised, synchronously read instruction memory for the pipeline's IF stage. It holds a cell-addressed program store, `CELL_W` bits per cell, and returns one instruction per fetch. The instruction is `CELLS_PER_WORD` consecutive cells concatenated big-endian. A streaming loader fills the store at run time, so no program is hard-coded. The fetch side has a registered response, a stall hold and an error flag for illegal addresses.

---
 rtl/instr_mem_pkg.sv | 9 +
 rtl/instr_mem_loader.sv | 40 ++++
 rtl/instr_fetch_mem.sv | 74 +++++++
 tb/tb_instr_fetch_mem.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: shared constants, state type and NOP word for the instruction fetch memory.
package instr_mem_pkg;
  localparam int IFM_CELL_W = 4;
  localparam int IFM_CELLS_PER_WORD = 4;
  localparam int IFM_DEPTH = 1024;
  localparam int IFM_WORD_W = IFM_CELL_W * IFM_CELLS_PER_WORD;
  localparam logic [IFM_WORD_W-1:0] NOP_WORD = '0;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} ifm_state_t;
endpackage

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: write pointer, cell accept and load_done pulse for the streaming program loader.
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int DEPTH = IFM_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          active,
  input  logic          load_valid,
  input  logic          load_last,
  output logic          load_ready,
  output logic          load_done,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic          finish
);
  logic [AW-1:0] ptr_q, ptr_d;
  logic done_q, done_d;
  always_comb begin
    load_ready = active;
    we = load_valid && active;
    finish = we && (load_last || ptr_q == AW'(DEPTH - 1));
    ptr_d = start ? '0 : we ? ptr_q + 1'b1 : ptr_q;
    done_d = finish;
    waddr = ptr_q;
    load_done = done_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      done_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      done_q <= done_d;
    end
  end
endmodule

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: loadable cell-addressed instruction store with a registered, stallable fetch port.
module instr_fetch_mem
  import instr_mem_pkg::*;
#(
  parameter int CELL_W = IFM_CELL_W,
  parameter int CELLS_PER_WORD = IFM_CELLS_PER_WORD,
  parameter int DEPTH = IFM_DEPTH,
  parameter int ADDR_W = 32,
  localparam int WORD_W = CELL_W * CELLS_PER_WORD,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [CELL_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  output logic              fetch_ready,
  output logic              instr_valid,
  output logic [WORD_W-1:0] instruction,
  output logic              fetch_err
);
  logic [CELL_W-1:0] mem [DEPTH];
  ifm_state_t state_q, state_d;
  logic valid_q, valid_d, err_q, err_d;
  logic [WORD_W-1:0] instr_q, instr_d, word;
  logic start, we, finish, accept, legal;
  logic [AW-1:0] waddr, base;
  instr_mem_loader #(.DEPTH(DEPTH)) u_loader (
    .clk(clk), .rst(rst), .start(start), .active(state_q == LOAD),
    .load_valid(load_valid), .load_last(load_last), .load_ready(load_ready),
    .load_done(load_done), .we(we), .waddr(waddr), .finish(finish)
  );
  always_comb begin
    start = state_q != LOAD && load_en;
    state_d = state_q == IDLE ? (load_en ? LOAD : RUN) :
              state_q == LOAD ? (finish ? RUN : LOAD) :
              (load_en ? LOAD : RUN);
    fetch_ready = state_q == RUN && !load_en && !stall;
    accept = fetch_req && fetch_ready;
    legal = fetch_addr % ADDR_W'(CELLS_PER_WORD) == '0 && fetch_addr <= ADDR_W'(DEPTH - CELLS_PER_WORD);
    base = fetch_addr[AW-1:0];
    word = '0;
    for (int i = 0; i < CELLS_PER_WORD; i++) word[WORD_W-1-i*CELL_W -: CELL_W] = mem[base + AW'(i)];
    valid_d = start ? 1'b0 : accept ? 1'b1 : stall ? valid_q : 1'b0;
    instr_d = accept ? (legal ? word : WORD_W'(NOP_WORD)) : instr_q;
    err_d = accept ? !legal : err_q;
    instr_valid = valid_q;
    instruction = instr_q;
    fetch_err = err_q;
  end
  // Cell array is deliberately outside reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= load_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      instr_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb_instr_fetch_mem: directed self-checking bench for load, fetch, stall, error and reset behaviour.
module tb_instr_fetch_mem;
  logic clk = 1'b0, rst = 1'b1;
  logic load_en = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [3:0] load_data = '0;
  logic load_ready, load_done;
  logic fetch_req = 1'b0, stall = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic fetch_ready, instr_valid, fetch_err;
  logic [15:0] instruction;
  int n_chk = 0, n_fail = 0;
  logic [3:0] prog [12] = '{4'd3, 4'd3, 4'd0, 4'd3, 4'd3, 4'd7, 4'd0, 4'd7, 4'd0, 4'd3, 4'd7, 4'd1};

  instr_fetch_mem #(.CELL_W(4), .CELLS_PER_WORD(4), .DEPTH(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .stall(stall), .fetch_ready(fetch_ready), .instr_valid(instr_valid),
    .instruction(instruction), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req = 1'b1;
    fetch_addr = a;
    tick();
  endtask

  initial begin
    tick(); tick();
    chk("rst_load_ready", 32'(load_ready), 0);
    chk("rst_load_done", 32'(load_done), 0);
    chk("rst_fetch_ready", 32'(fetch_ready), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", 32'(instruction), 0);
    chk("rst_err", 32'(fetch_err), 0);
    rst = 1'b0;
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    chk("load_ready", 32'(load_ready), 1);
    for (int i = 0; i < 12; i++) begin
      load_valid = 1'b1;
      load_data = prog[i];
      load_last = (i == 11);
      tick();
      if (i == 10) chk("no_early_done", 32'(load_done), 0);
    end
    load_valid = 1'b0;
    load_last = 1'b0;
    chk("load_done_pulse", 32'(load_done), 1);
    chk("fetch_ready_on_done", 32'(fetch_ready), 1);
    chk("load_ready_off", 32'(load_ready), 0);
    fetch(0);
    chk("done_one_cycle", 32'(load_done), 0);
    chk("f0_valid", 32'(instr_valid), 1);
    chk("f0_instr", 32'(instruction), 32'h3303);
    chk("f0_err", 32'(fetch_err), 0);
    fetch(4);
    chk("f4_instr", 32'(instruction), 32'h3707);
    chk("f4_err", 32'(fetch_err), 0);
    fetch(8);
    chk("f8_instr", 32'(instruction), 32'h0371);
    chk("f8_err", 32'(fetch_err), 0);
    fetch(2);
    chk("f2_valid", 32'(instr_valid), 1);
    chk("f2_err", 32'(fetch_err), 1);
    chk("f2_instr", 32'(instruction), 0);
    fetch(28);
    chk("f28_valid", 32'(instr_valid), 1);
    chk("f28_err", 32'(fetch_err), 0);
    fetch(32);
    chk("f32_err", 32'(fetch_err), 1);
    chk("f32_instr", 32'(instruction), 0);
    fetch_req = 1'b0;
    tick();
    chk("valid_drop", 32'(instr_valid), 0);
    fetch(4);
    chk("st_f4", 32'(instruction), 32'h3707);
    stall = 1'b1;
    fetch_addr = 8;
    #1;
    chk("st_fetch_ready", 32'(fetch_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_hold_instr", 32'(instruction), 32'h3707);
      chk("st_hold_valid", 32'(instr_valid), 1);
    end
    stall = 1'b0;
    tick();
    chk("st_release", 32'(instruction), 32'h0371);
    fetch_req = 1'b0;
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    chk("full_enter_valid", 32'(instr_valid), 0);
    for (int i = 0; i < 32; i++) begin
      load_valid = 1'b1;
      load_data = 4'(i) ^ 4'hA;
      tick();
    end
    chk("full_done", 32'(load_done), 1);
    chk("full_ready_off", 32'(load_ready), 0);
    load_data = 4'hF;
    tick();
    load_valid = 1'b0;
    chk("full_done_once", 32'(load_done), 0);
    fetch(28);
    chk("full_f28", 32'(instruction), 32'h6745);
    fetch(0);
    chk("full_f0", 32'(instruction), 32'hAB89);
    fetch_req = 1'b0;
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      load_valid = 1'b1;
      load_data = 4'(i);
      tick();
    end
    load_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_load_ready", 32'(load_ready), 0);
    chk("mr_load_done", 32'(load_done), 0);
    chk("mr_fetch_ready", 32'(fetch_ready), 0);
    chk("mr_valid", 32'(instr_valid), 0);
    chk("mr_instr", 32'(instruction), 0);
    chk("mr_err", 32'(fetch_err), 0);
    tick();
    chk("mr_run", 32'(fetch_ready), 1);
    fetch(0);
    chk("mr_f0", 32'(instruction), 32'h1234);
    fetch(4);
    chk("mr_f4", 32'(instruction), 32'h5FCD);
    fetch_addr = 8;
    load_en = 1'b1;
    tick();
    fetch_req = 1'b0;
    load_en = 1'b0;
    chk("pr_valid", 32'(instr_valid), 0);
    chk("pr_load_ready", 32'(load_ready), 1);
    chk("pr_instr_kept", 32'(instruction), 32'h5FCD);
    load_valid = 1'b1;
    load_data = 4'h9;
    load_last = 1'b1;
    tick();
    load_valid = 1'b0;
    load_last = 1'b0;
    chk("pr_done", 32'(load_done), 1);
    fetch(0);
    chk("pr_f0", 32'(instruction), 32'h9234);
    fetch_req = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
